// File: rtl/fetch_unit.sv
// Instruction fetch / program-counter stage of the ternary CPU: holds PC and IR,
// decodes the IR fields and advances the PC (with BEQ/BNE) on the FSM's do_next strobe.
module fetch_unit #(
  parameter int INSTR_WIDTH = 18,
  parameter int OPCODE_SIZE = 6,
  parameter int PC_WIDTH    = 8,
  parameter int REG_SEL     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   do_fetch,
  input  logic                   do_next,
  input  logic                   do_reset,
  input  logic                   do_halt,
  input  logic                   regs_equal,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [OPCODE_SIZE-1:0] opcode,
  output logic [REG_SEL-1:0]     rd,
  output logic [REG_SEL-1:0]     rs1,
  output logic [REG_SEL-1:0]     rs2,
  output logic [7:0]             imm,
  output logic                   is_alu_operation,
  output logic [15:0]            retired,
  output logic                   halted
);

  // Opcode table shared with the control FSM; codes 1..7 form the ALU class.
  localparam logic [OPCODE_SIZE-1:0] OP_ADD = OPCODE_SIZE'(1);
  localparam logic [OPCODE_SIZE-1:0] OP_SUB = OPCODE_SIZE'(2);
  localparam logic [OPCODE_SIZE-1:0] OP_AND = OPCODE_SIZE'(3);
  localparam logic [OPCODE_SIZE-1:0] OP_OR  = OPCODE_SIZE'(4);
  localparam logic [OPCODE_SIZE-1:0] OP_XOR = OPCODE_SIZE'(5);
  localparam logic [OPCODE_SIZE-1:0] OP_SHL = OPCODE_SIZE'(6);
  localparam logic [OPCODE_SIZE-1:0] OP_SHR = OPCODE_SIZE'(7);
  localparam logic [OPCODE_SIZE-1:0] OP_BEQ = OPCODE_SIZE'(11);
  localparam logic [OPCODE_SIZE-1:0] OP_BNE = OPCODE_SIZE'(12);

  logic signed [7:0]    imm_s;
  logic                 branch_taken;
  logic [PC_WIDTH-1:0]  pc_next;

  // Branch offsets are relative to the branch's own PC and wrap modulo 2^PC_WIDTH.
  function automatic logic [PC_WIDTH-1:0] advance_pc(
    input logic [PC_WIDTH-1:0] cur,
    input logic                take,
    input logic signed [7:0]   off
  );
    logic signed [PC_WIDTH-1:0] off_ext;
    off_ext = PC_WIDTH'(off);
    return take ? cur + $unsigned(off_ext) : cur + PC_WIDTH'(1);
  endfunction

  assign opcode    = instr[INSTR_WIDTH-1 -: OPCODE_SIZE];
  assign rd        = instr[11:8];
  assign rs1       = instr[7:4];
  assign rs2       = instr[3:0];
  assign imm       = instr[7:0];
  assign imm_s     = imm;
  assign imem_addr = pc;

  always_comb begin
    is_alu_operation = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR};
    branch_taken     = ((opcode == OP_BEQ) && regs_equal) || ((opcode == OP_BNE) && !regs_equal);
    pc_next          = advance_pc(pc, branch_taken, imm_s);
  end

  always_ff @(posedge clock) begin
    if (reset || do_reset) begin
      pc      <= '0;
      instr   <= '0;
      retired <= '0;
      halted  <= 1'b0;
    end else if (do_halt) begin
      halted <= 1'b1;
    end else if (do_next) begin
      pc      <= pc_next;
      retired <= retired + 16'd1;
    end else if (do_fetch) begin
      instr <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a cycle model of PC/IR behaviour checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fetch_unit;

  localparam int OP_NOP = 0, OP_ADD = 1, OP_SUB = 2, OP_LI = 8;
  localparam int OP_BEQ = 11, OP_BNE = 12, OP_HALT = 13;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        do_fetch = 1'b0, do_next = 1'b0, do_reset = 1'b0, do_halt = 1'b0;
  logic        regs_equal = 1'b0;
  logic [17:0] imem_data;
  logic [7:0]  imem_addr, pc, imm;
  logic [17:0] instr;
  logic [5:0]  opcode;
  logic [3:0]  rd, rs1, rs2;
  logic        is_alu_operation, halted;
  logic [15:0] retired;

  logic [17:0] rom [256];
  assign imem_data = rom[imem_addr];

  fetch_unit dut (
    .clock(clock), .reset(reset), .do_fetch(do_fetch), .do_next(do_next),
    .do_reset(do_reset), .do_halt(do_halt), .regs_equal(regs_equal),
    .imem_data(imem_data), .imem_addr(imem_addr), .pc(pc), .instr(instr),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .is_alu_operation(is_alu_operation), .retired(retired), .halted(halted)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] mk(input int op, input int rdv, input int immv);
    return 18'((op << 12) | (rdv << 8) | (immv & 255));
  endfunction

  // Reference model: plain integers, updated once per rising edge.
  int m_pc = 0, m_instr = 0, m_ret = 0;
  bit m_halt = 1'b0;

  function automatic int model_next_pc(input int cur, input int ir, input bit eq);
    int op, off;
    bit take;
    op   = (ir >> 12) & 63;
    off  = ir & 255;
    if (off >= 128) off = off - 256;
    take = (op == OP_BEQ && eq) || (op == OP_BNE && !eq);
    return take ? (cur + off + 256) % 256 : (cur + 1) % 256;
  endfunction

  always @(posedge clock) begin
    if (reset || do_reset) begin
      m_pc <= 0; m_instr <= 0; m_ret <= 0; m_halt <= 1'b0;
    end else if (do_halt) begin
      m_halt <= 1'b1;
    end else if (do_next) begin
      m_pc  <= model_next_pc(m_pc, m_instr, regs_equal);
      m_ret <= (m_ret + 1) % 65536;
    end else if (do_fetch) begin
      m_instr <= int'(rom[m_pc]);
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      int op;
      op = (m_instr >> 12) & 63;
      check("pc", int'(pc), m_pc);
      check("imem_addr", int'(imem_addr), m_pc);
      check("instr", int'(instr), m_instr);
      check("opcode", int'(opcode), op);
      check("rd", int'(rd), (m_instr >> 8) & 15);
      check("rs1", int'(rs1), (m_instr >> 4) & 15);
      check("rs2", int'(rs2), m_instr & 15);
      check("imm", int'(imm), m_instr & 255);
      check("is_alu", int'(is_alu_operation), int'(op >= 1 && op <= 7));
      check("retired", int'(retired), m_ret);
      check("halted", int'(halted), int'(m_halt));
    end
  end

  // Drive one cycle's strobes at the falling edge; they take effect at the next rising edge.
  task automatic step(input bit f, input bit n, input bit h, input bit eq);
    @(negedge clock);
    reset = 1'b0; do_reset = 1'b0;
    do_fetch = f; do_next = n; do_halt = h; regs_equal = eq;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_rst(input bit use_fsm);
    @(negedge clock);
    do_fetch = 1'b0; do_next = 1'b0; do_halt = 1'b0; regs_equal = 1'b0;
    reset = !use_fsm; do_reset = use_fsm;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  // Jump from pc 0 to target with a taken BEQ, then run one branch at target.
  task automatic run_branch(input int op, input bit eq, input int exp_pc, input string name);
    clear_rom();
    rom[0]  = mk(OP_BEQ, 0, 10);
    rom[10] = mk(op, 0, 8'hFB);
    do_rst(1'b0);
    step(1, 0, 0, 0); idle(); step(0, 1, 0, 1);
    step(1, 0, 0, 0); idle(); step(0, 1, 0, eq);
    idle();
    check(name, int'(pc), exp_pc);
  endtask

  initial begin
    clear_rom();
    do_rst(1'b0);
    idle();
    cmp_en = 1'b1;
    check("reset_pc", int'(pc), 0);
    check("reset_addr", int'(imem_addr), 0);
    check("reset_instr", int'(instr), 0);
    check("reset_halted", int'(halted), 0);

    // Sequential LI, ADD, HALT
    rom[0] = mk(OP_LI, 1, 5);
    rom[1] = mk(OP_ADD, 2, 8'h11);
    rom[2] = mk(OP_HALT, 0, 0);
    step(1, 0, 0, 0); idle();
    check("seq_li_alu", int'(is_alu_operation), 0);
    step(0, 1, 0, 0); idle();
    check("seq_pc1", int'(pc), 1);
    step(1, 0, 0, 0); idle();
    check("seq_add_alu", int'(is_alu_operation), 1);
    idle(); step(0, 1, 0, 0); idle();
    check("seq_pc2", int'(pc), 2);
    step(1, 0, 0, 0); idle();
    check("seq_halt_alu", int'(is_alu_operation), 0);
    step(0, 0, 1, 0); idle();
    check("seq_halted", int'(halted), 1);
    check("seq_retired", int'(retired), 2);

    // Branches at pc 10 with offset -5
    run_branch(OP_BEQ, 1'b1, 5,  "beq_taken");
    run_branch(OP_BEQ, 1'b0, 11, "beq_not_taken");
    run_branch(OP_BNE, 1'b1, 11, "bne_not_taken");
    run_branch(OP_BNE, 1'b0, 5,  "bne_taken");

    // Wrap 255 -> 0
    clear_rom();
    rom[0]   = mk(OP_BEQ, 0, 8'hFF);
    rom[255] = mk(OP_ADD, 1, 0);
    do_rst(1'b1);
    step(1, 0, 0, 0); step(0, 1, 0, 1); idle();
    check("wrap_to_255", int'(pc), 255);
    step(1, 0, 0, 0); step(0, 1, 0, 0); idle();
    check("wrap_to_0", int'(pc), 0);

    // Backward wrap 2 -> 254
    clear_rom();
    rom[2] = mk(OP_BEQ, 0, 8'hFC);
    do_rst(1'b0);
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(1, 0, 0, 0); step(0, 1, 0, 1); idle();
    check("wrap_to_254", int'(pc), 254);
    check("wrap_retired", int'(retired), 3);

    // Halt with colliding strobes freezes everything
    step(1, 1, 1, 1); idle(); idle();
    check("halt_pc", int'(pc), 254);
    check("halt_instr", int'(instr), int'(mk(OP_BEQ, 0, 8'hFC)));
    check("halt_retired", int'(retired), 3);
    check("halt_sticky", int'(halted), 1);
    step(0, 1, 0, 0); step(1, 0, 0, 0); idle();
    check("halt_stays", int'(halted), 1);

    // Reset mid-operation at pc 37, via reset and then via do_reset
    for (int k = 0; k < 2; k++) begin
      clear_rom();
      rom[0]  = mk(OP_BEQ, 0, 37);
      rom[37] = mk(OP_SUB, 3, 8'h21);
      do_rst(1'b0);
      step(1, 0, 0, 0); step(0, 1, 0, 1); step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      idle();
      check("mid_pc_before", int'(pc), 37);
      do_rst(k == 1);
      idle();
      check("mid_pc", int'(pc), 0);
      check("mid_instr", int'(instr), 0);
      check("mid_retired", int'(retired), 0);
      check("mid_halted", int'(halted), 0);
    end

    // Fetch/next collision: PC advances, IR holds
    clear_rom();
    rom[0] = mk(OP_ADD, 1, 8'h23);
    rom[1] = mk(OP_SUB, 2, 8'h45);
    do_rst(1'b0);
    step(1, 0, 0, 0); step(1, 1, 0, 0); idle();
    check("coll_pc", int'(pc), 1);
    check("coll_instr", int'(instr), int'(mk(OP_ADD, 1, 8'h23)));
    idle();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
